result_digit_tx: RTL

- Output side of the multiplier datapath: takes the signed binary product plus its valid strobe and converts the magnitude to decimal digits.
- Conversion is sequential double-dabble, one bit per cycle.
- Digits are then transmitted one per beat, most significant first, over a valid/ready handshake to the display/serial stage.
- Counterpart of the digit-capture front end: that stage turns digits into binary; this one turns binary back into digits.

---
 rtl/result_pkg.sv | 21 ++
 rtl/bcd_add3.sv | 9 +
 rtl/result_digit_tx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/result_pkg.sv
// Shared types and constants for the product-to-digits output stage.
package result_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SEND,
    DONE
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Largest value representable in num_dig decimal digits (10^num_dig - 1).
  function automatic int unsigned max_decimal(input int unsigned num_dig);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < num_dig; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/result_digit_tx.sv
// Converts a signed product magnitude to BCD (one bit per cycle) and streams the
// digits MSD first over valid/ready. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module result_digit_tx
  import result_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int NUM_DIG = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [BIN_W-1:0]           producto,
  input  logic                       signo_in,
  output logic                       busy,
  output logic                       signo_out,
  output logic                       ovf,
  output logic [3:0]                 dig_out,
  output logic [$clog2(NUM_DIG)-1:0] dig_idx,
  output logic                       dig_valid,
  input  logic                       dig_ready,
  output logic                       dig_last,
  output logic                       done
);

  localparam int IDX_W = $clog2(NUM_DIG);
  localparam int BCD_W = 4 * NUM_DIG;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(max_decimal(NUM_DIG));
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BIN_W - 1);
  localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(NUM_DIG - 1);

  state_t             state;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   sel_idx;
  logic [3:0]         sel_code;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib (bcd_reg[4*g +: 4]),
      .adj (bcd_adj[4*g +: 4])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIG-1:0] lead_zero;

  // lead_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      all_zero     = all_zero & (bcd_reg[4*i +: 4] == 4'd0);
      lead_zero[i] = all_zero;
    end
  end
`endif

  // Next beat to present: the current index on SEND entry, otherwise the one below.
  always_comb begin
    sel_idx  = dig_valid ? dig_idx - 1'b1 : dig_idx;
    sel_code = bcd_reg[4*sel_idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (sel_idx != '0 && lead_zero[sel_idx]) sel_code = BLANK_CODE;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      signo_out <= 1'b0;
      ovf       <= 1'b0;
      dig_out   <= '0;
      dig_idx   <= '0;
      dig_valid <= 1'b0;
      dig_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            busy      <= 1'b1;
            bit_cnt   <= '0;
            bcd_reg   <= '0;
            signo_out <= signo_in & (producto != '0);
            if (producto > MAX_BIN) begin
              bin_reg <= MAX_BIN;
              ovf     <= 1'b1;
            end else begin
              bin_reg <= producto;
              ovf     <= 1'b0;
            end
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
          bit_cnt            <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            dig_idx <= TOP_IDX;
            state   <= SEND;
          end
        end
        SEND: begin
          if (!dig_valid) begin
            dig_valid <= 1'b1;
            dig_out   <= sel_code;
            dig_last  <= (sel_idx == '0);
          end else if (dig_ready) begin
            if (dig_last) begin
              dig_valid <= 1'b0;
              dig_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              dig_idx  <= sel_idx;
              dig_out  <= sel_code;
              dig_last <= (sel_idx == '0);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
